// File: rtl/pixel_unpacker.sv
// Unpacks 24-bit RGB pixels from a 32-bit AXI4-Stream (4 pixels per 3 words) and rebuilds x/y, framing errors and frame count.
// Latency: first pixel of a word appears one cycle after acceptance. Backpressure: tready drops while a pixel is stalled or p3 is pending.
module pixel_unpacker #(
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [31:0]            in_stream_tdata,
  input  logic [3:0]             in_stream_tkeep,
  input  logic                   in_stream_tlast,
  input  logic                   in_stream_tuser,
  input  logic                   in_stream_tvalid,
  output logic                   in_stream_tready,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic [9:0]             x,
  output logic [8:0]             y,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   sof_err,
  output logic                   eol_err,
  input  logic                   err_clear,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {PH0, PH1, PH2, EMIT3} state_t;

  localparam logic [9:0] XL  = 10'(X_SIZE - 1);
  localparam logic [9:0] XL2 = 10'(X_SIZE - 2);
  localparam logic [8:0] YL  = 9'(Y_SIZE - 1);

  state_t      state, eff_state;
  logic [23:0] carry;
  logic [9:0]  nx, ex;
  logic [8:0]  ny, ey;
  logic        force_eol;
  logic [7:0]  pr, pg, pb;
  logic        accept, line_end, tlast_bad, tlast_miss, sof_bad, brk_now;

  // Coordinate that follows (px,py); brk forces a jump to the start of the next line.
  function automatic logic [18:0] step_xy(input logic [9:0] px, input logic [8:0] py, input logic brk);
    logic [8:0] ny1;
    ny1 = (py == YL) ? 9'd0 : py + 9'd1;
    if (brk || px == XL) return {ny1, 10'd0};
    return {py, px + 10'd1};
  endfunction

  assign in_stream_tready = aresetn & (~pix_valid | pix_ready) & (state != EMIT3);
  assign accept           = in_stream_tvalid & in_stream_tready;

  always_comb begin
    eff_state = in_stream_tuser ? PH0 : state;
    ex        = in_stream_tuser ? 10'd0 : nx;
    ey        = in_stream_tuser ? 9'd0 : ny;
    pr        = in_stream_tdata[23:16];
    pg        = in_stream_tdata[15:8];
    pb        = in_stream_tdata[7:0];
    case (eff_state)
      PH1: begin
        pb = carry[7:0];
        pg = in_stream_tdata[7:0];
        pr = in_stream_tdata[15:8];
      end
      PH2: begin
        pb = carry[7:0];
        pg = carry[15:8];
        pr = in_stream_tdata[7:0];
      end
      default: ;
    endcase
    line_end   = (eff_state == PH2) && (ex == XL2);
    tlast_bad  = in_stream_tlast & ~line_end;
    tlast_miss = ~in_stream_tlast & line_end;
    sof_bad    = in_stream_tuser & ((state != PH0) | (nx != '0) | (ny != '0));
    brk_now    = tlast_bad & (eff_state != PH2);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= PH0;
      carry       <= '0;
      nx          <= '0;
      ny          <= '0;
      force_eol   <= 1'b0;
      pix_valid   <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      x           <= '0;
      y           <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      if (pix_valid && pix_ready && x == XL && y == YL)
        frame_count <= frame_count + FRAME_CNT_W'(1);

      if (accept) begin
        pix_valid <= 1'b1;
        r         <= pr;
        g         <= pg;
        b         <= pb;
        x         <= ex;
        y         <= ey;
        pix_sof   <= (ex == '0) && (ey == '0);
        pix_eol   <= (ex == XL);
        {ny, nx}  <= step_xy(ex, ey, brk_now);
        force_eol <= tlast_bad & (eff_state == PH2);
        case (eff_state)
          PH0: begin
            carry <= {16'h0, in_stream_tdata[31:24]};
            state <= PH1;
          end
          PH1: begin
            carry <= {8'h0, in_stream_tdata[31:16]};
            state <= PH2;
          end
          default: begin
            carry <= in_stream_tdata[31:8];
            state <= EMIT3;
          end
        endcase
        // A misplaced tlast on W0/W1 drops the held bytes and restarts the word cycle.
        if (brk_now) begin
          carry <= '0;
          state <= PH0;
        end
      end else if (state == EMIT3) begin
        if (pix_ready) begin
          pix_valid <= 1'b1;
          r         <= carry[23:16];
          g         <= carry[15:8];
          b         <= carry[7:0];
          x         <= nx;
          y         <= ny;
          pix_sof   <= (nx == '0) && (ny == '0);
          pix_eol   <= (nx == XL);
          {ny, nx}  <= step_xy(nx, ny, force_eol);
          force_eol <= 1'b0;
          carry     <= '0;
          state     <= PH0;
        end
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end

      if (err_clear) begin
        sof_err <= 1'b0;
        eol_err <= 1'b0;
      end else if (accept) begin
        if (sof_bad) sof_err <= 1'b1;
        if (tlast_bad | tlast_miss) eol_err <= 1'b1;
      end
    end
  end

  keep_full_a: assert property (@(posedge aclk) disable iff (!aresetn)
    in_stream_tvalid |-> in_stream_tkeep == 4'hF);

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized scoreboard bench for pixel_unpacker against a byte-queue reference model.
module tb_pixel_unpacker;

  localparam int XS = 16;
  localparam int YS = 6;
  localparam int FW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   in_stream_tdata = '0;
  logic [3:0]    in_stream_tkeep = 4'hF;
  logic          in_stream_tlast = 1'b0;
  logic          in_stream_tuser = 1'b0;
  logic          in_stream_tvalid = 1'b0;
  logic          in_stream_tready;
  logic [7:0]    r, g, b;
  logic [9:0]    x;
  logic [8:0]    y;
  logic          pix_sof, pix_eol, pix_valid;
  logic          pix_ready = 1'b0;
  logic          sof_err, eol_err;
  logic          err_clear = 1'b0;
  logic [FW-1:0] frame_count;

  always #5 aclk = ~aclk;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .FRAME_CNT_W(FW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
    .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
    .r(r), .g(g), .b(b), .x(x), .y(y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sof_err(sof_err), .eol_err(eol_err), .err_clear(err_clear),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [7:0] r, g, b;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof, eol;
  } pix_t;

  pix_t       exp_q[$];
  logic [7:0] m_bytes[$];
  int         m_x, m_y, exp_frames;
  bit         m_sof, m_eol;
  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 1;
  bit         gap_en = 0;
  logic [31:0] dir_w [3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_x = 0; m_y = 0; exp_frames = 0;
    m_sof = 0; m_eol = 0;
  endtask

  // Bytes stream in lane order; every 3 bytes form one (b,g,r) pixel at the running coordinate.
  task automatic model_word(input logic [31:0] d, input logic u, input logic l);
    bit   line_done;
    pix_t e;
    logic [7:0] pb8, pg8, pr8;
    line_done = 0;
    if (u) begin
      if (m_bytes.size() != 0 || m_x != 0 || m_y != 0) m_sof = 1;
      m_bytes.delete();
      m_x = 0; m_y = 0;
    end
    for (int i = 0; i < 4; i++) m_bytes.push_back(d[8*i +: 8]);
    while (m_bytes.size() >= 3) begin
      pb8 = m_bytes.pop_front();
      pg8 = m_bytes.pop_front();
      pr8 = m_bytes.pop_front();
      e = {pr8, pg8, pb8, 10'(m_x), 9'(m_y), 1'(m_x == 0 && m_y == 0), 1'(m_x == XS - 1)};
      exp_q.push_back(e);
      if (m_x == XS - 1 && m_y == YS - 1) exp_frames++;
      if (m_x == XS - 1) begin
        line_done = 1;
        m_x = 0;
        m_y = (m_y + 1) % YS;
      end else begin
        m_x++;
      end
    end
    if (l && !line_done) begin
      m_eol = 1;
      m_bytes.delete();
      m_x = 0;
      m_y = (m_y + 1) % YS;
    end else if (!l && line_done) begin
      m_eol = 1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic u, input logic l);
    int n;
    if (gap_en)
      while ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
    model_word(d, u, l);
    in_stream_tdata  = d;
    in_stream_tuser  = u;
    in_stream_tlast  = l;
    in_stream_tvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!in_stream_tready && n < 2000) begin @(negedge aclk); n++; end
    if (!in_stream_tready) begin
      checks++; errors++;
      $display("FAIL word accept timeout data=%h", d);
    end
    @(posedge aclk); #1;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tlast  = 1'b0;
  endtask

  task automatic send_frame(input bit directed);
    logic [31:0] d;
    for (int yy = 0; yy < YS; yy++)
      for (int gi = 0; gi < XS / 4; gi++)
        for (int w = 0; w < 3; w++) begin
          d = $urandom();
          if (directed && yy == 0 && gi == 0) d = dir_w[w];
          send_word(d, 1'(yy == 0 && gi == 0 && w == 0), 1'(gi == XS / 4 - 1 && w == 2));
        end
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge aclk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain timeout pixels_left=%0d", exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, " sof_err"}, 32'(sof_err), 32'(m_sof));
    chk({tag, " eol_err"}, 32'(eol_err), 32'(m_eol));
    chk({tag, " frame_count"}, 32'(frame_count), 32'(exp_frames % (1 << FW)));
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(posedge aclk); #1;
    err_clear = 1'b0;
    m_sof = 0; m_eol = 0;
    chk("err_clear", 32'({sof_err, eol_err}), 32'(0));
  endtask

  initial begin
    forever begin
      @(posedge aclk); #2;
      case (ready_mode)
        0:       pix_ready = ($urandom_range(0, 3) != 0);
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'b0;
      endcase
    end
  end

  initial begin
    pix_t act, e;
    forever begin
      @(negedge aclk);
      if (aresetn && pix_valid && pix_ready) begin
        act = {r, g, b, x, y, pix_sof, pix_eol};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel unexpected r=%h g=%h b=%h x=%0d y=%0d", r, g, b, x, y);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL pixel act rgb=%h%h%h x=%0d y=%0d sof=%b eol=%b exp rgb=%h%h%h x=%0d y=%0d sof=%b eol=%b",
                     act.r, act.g, act.b, act.x, act.y, act.sof, act.eol,
                     e.r, e.g, e.b, e.x, e.y, e.sof, e.eol);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("reset tready", 32'(in_stream_tready), 32'(0));
    chk("reset pix_valid", 32'(pix_valid), 32'(0));
    chk("reset rgb", 32'({r, g, b}), 32'(0));
    chk("reset xy", 32'({x, y}), 32'(0));
    chk("reset sof_eol", 32'({pix_sof, pix_eol}), 32'(0));
    chk("reset errs", 32'({sof_err, eol_err}), 32'(0));
    chk("reset frame_count", 32'(frame_count), 32'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Directed opening words, full frame, no stalls
    ready_mode = 1; gap_en = 0;
    send_frame(1);
    drain();
    check_flags("frame1");

    // Second frame with random source gaps and sink stalls
    ready_mode = 0; gap_en = 1;
    send_frame(0);
    drain();
    check_flags("frame2");

    // tlast on W1 at x=5
    gap_en = 0;
    send_word($urandom(), 1, 0);
    send_word($urandom(), 0, 0);
    send_word($urandom(), 0, 0);
    send_word($urandom(), 0, 0);
    send_word($urandom(), 0, 1);
    for (int i = 0; i < 3; i++) send_word($urandom(), 0, 0);
    drain();
    check_flags("tlast_w1");
    clear_errs();

    // tuser mid-line at x=8
    for (int i = 0; i < 3; i++) send_word($urandom(), 0, 0);
    send_word($urandom(), 1, 0);
    send_word($urandom(), 0, 0);
    send_word($urandom(), 0, 0);
    drain();
    check_flags("tuser_mid");
    clear_errs();

    // Line ending without tlast
    for (int i = 0; i < 9; i++) send_word($urandom(), 0, 0);
    drain();
    check_flags("no_tlast");
    clear_errs();

    // Sink stall while p3 is pending
    send_word($urandom(), 0, 0);
    send_word($urandom(), 0, 0);
    send_word($urandom(), 0, 0);
    ready_mode = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("stall tready", 32'(in_stream_tready), 32'(0));
      chk("stall valid", 32'(pix_valid), 32'(1));
      if (exp_q.size() == 2)
        chk("stall p2 held", 32'({r, g, b}), 32'({exp_q[0].r, exp_q[0].g, exp_q[0].b}));
      else
        chk("stall queue depth", 32'(exp_q.size()), 32'(2));
    end
    @(posedge aclk); #1;
    drain();
    check_flags("stall");

    // Random framing storm
    ready_mode = 0; gap_en = 1;
    for (int i = 0; i < 300; i++)
      send_word($urandom(), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 14) == 0));
    drain();
    check_flags("storm");
    clear_errs();
    ready_mode = 0;
    send_frame(0);
    drain();
    check_flags("frame3");

    // Reset while W1 is being offered
    gap_en = 0;
    send_word(32'h12345678, 1, 0);
    in_stream_tdata  = 32'h9ABCDEF0;
    in_stream_tvalid = 1'b1;
    aresetn          = 1'b0;
    model_reset();
    @(negedge aclk);
    chk("midreset tready", 32'(in_stream_tready), 32'(0));
    @(posedge aclk);
    @(negedge aclk);
    chk("midreset pix_valid", 32'(pix_valid), 32'(0));
    chk("midreset xy", 32'({x, y}), 32'(0));
    chk("midreset frame_count", 32'(frame_count), 32'(0));
    @(posedge aclk); #1;
    aresetn          = 1'b1;
    in_stream_tvalid = 1'b0;
    send_word(32'h0A0B0C0D, 1, 0);
    drain();
    check_flags("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
